// File: rtl/line_buffer_ctrl.sv
// Ping-pong line buffer sequencer: one bank of the external simple dual-port
// RAM fills from the input stream while the other bank drains to the output
// stream through a 2-entry skid buffer.
//
// Write FSM
//   state   | meaning
//   W_FILL  | bank[wr_bank] is FREE, input beats are accepted
//   W_WAIT  | bank[wr_bank] still FULL, waiting for the reader to free it
// Read FSM
//   state   | meaning
//   R_IDLE  | bank[rd_bank] holds no complete line
//   R_DRAIN | bank[rd_bank] is FULL, reads are issued as skid space allows
module line_buffer_ctrl #(
    parameter int SIZE       = 24,
    parameter int LINE_WIDTH = 1280,
    localparam int CW        = $clog2(LINE_WIDTH + 1),
    localparam int AW        = $clog2(2 * LINE_WIDTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [SIZE-1:0] in_data,
    input  logic            in_last,
    output logic            in_ready,
    output logic            out_valid,
    output logic [SIZE-1:0] out_data,
    output logic            out_last,
    input  logic            out_ready,
    output logic [AW-1:0]   ram_waddr,
    output logic [SIZE-1:0] ram_wdata,
    output logic            ram_wen,
    output logic [AW-1:0]   ram_raddr,
    input  logic [SIZE-1:0] ram_rdata,
    output logic            overflow,
    output logic [1:0]      lines_held
);

    typedef enum logic {W_FILL, W_WAIT} w_state_t;
    typedef enum logic {R_IDLE, R_DRAIN} r_state_t;

    w_state_t        w_state, w_next;
    r_state_t        r_state, r_next;
    logic [1:0]      full, full_n;
    logic [CW-1:0]   len_q [2];
    logic            wr_bank, rd_bank, wr_bank_n, rd_bank_n;
    logic [CW-1:0]   wcnt, rcnt;
    logic            infl, infl_last;
    logic [SIZE-1:0] sk_data [2];
    logic            sk_last [2];
    logic [1:0]      sk_cnt;
    logic [1:0]      occ;
    logic            wr_fire, wr_at_end, wr_close;
    logic            rd_active, rd_issue, rd_last_issue;
    logic            pop, sk_wr_idx;

    // Write side: accept, address and close decisions
    always_comb begin
        in_ready  = (w_state == W_FILL);
        wr_fire   = in_valid && in_ready;
        wr_at_end = (wcnt == CW'(LINE_WIDTH - 1));
        wr_close  = wr_fire && (in_last || wr_at_end);
        overflow  = wr_fire && wr_at_end && !in_last;
        ram_wen   = wr_fire;
        ram_wdata = in_data;
        ram_waddr = (wr_bank ? AW'(LINE_WIDTH) : AW'(0)) + AW'(wcnt);
    end

    // Read side: issue throttled so skid entries plus in-flight reads never exceed 2.
    // The first read may go out in the cycle the bank turns FULL, before the FSM
    // has registered R_DRAIN, which keeps first-pixel latency at two cycles.
    always_comb begin
        out_valid     = (sk_cnt != 2'd0);
        out_data      = sk_data[0];
        out_last      = sk_last[0];
        pop           = out_valid && out_ready;
        occ           = sk_cnt + {1'b0, infl} - {1'b0, pop};
        rd_active     = (r_state == R_DRAIN) || full[rd_bank];
        rd_issue      = rd_active && full[rd_bank] && (occ < 2'd2);
        rd_last_issue = rd_issue && (rcnt == len_q[rd_bank] - CW'(1));
        ram_raddr     = (rd_bank ? AW'(LINE_WIDTH) : AW'(0)) + AW'(rcnt);
        sk_wr_idx     = ((sk_cnt == 2'd1) && !pop) || ((sk_cnt == 2'd2) && pop);
        lines_held    = {1'b0, full[0]} + {1'b0, full[1]};
    end

    // Next bank occupancy and FSM next states; a close and a free in the same
    // cycle always touch different banks so both apply.
    always_comb begin
        full_n = full;
        if (wr_close)      full_n[wr_bank] = 1'b1;
        if (rd_last_issue) full_n[rd_bank] = 1'b0;
        wr_bank_n = wr_bank ^ wr_close;
        rd_bank_n = rd_bank ^ rd_last_issue;
        w_next    = full_n[wr_bank_n] ? W_WAIT : W_FILL;
        r_next    = full_n[rd_bank_n] ? R_DRAIN : R_IDLE;
    end

    // FSM state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_FILL;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // Bank bookkeeping: occupancy, lengths, bank pointers and pixel counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 2'b00;
            len_q[0] <= '0;
            len_q[1] <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wcnt     <= '0;
            rcnt     <= '0;
        end else begin
            full    <= full_n;
            wr_bank <= wr_bank_n;
            rd_bank <= rd_bank_n;
            if (wr_fire) wcnt <= wr_close ? '0 : wcnt + CW'(1);
            if (wr_close) len_q[wr_bank] <= wcnt + CW'(1);
            if (rd_issue) rcnt <= rd_last_issue ? '0 : rcnt + CW'(1);
        end
    end

    // Read pipeline and 2-entry skid buffer; head entry only moves on a pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl       <= 1'b0;
            infl_last  <= 1'b0;
            sk_cnt     <= 2'd0;
            sk_data[0] <= '0;
            sk_data[1] <= '0;
            sk_last[0] <= 1'b0;
            sk_last[1] <= 1'b0;
        end else begin
            infl      <= rd_issue;
            infl_last <= rd_last_issue;
            sk_cnt    <= sk_cnt + {1'b0, infl} - {1'b0, pop};
            if (pop) begin
                sk_data[0] <= sk_data[1];
                sk_last[0] <= sk_last[1];
            end
            if (infl) begin
                sk_data[sk_wr_idx] <= ram_rdata;
                sk_last[sk_wr_idx] <= infl_last;
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
module tb_line_buffer_ctrl;

    localparam int SIZE = 24;
    localparam int LW   = 8;
    localparam int AW   = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_last, in_ready;
    logic [SIZE-1:0] in_data;
    logic            out_valid, out_last, out_ready;
    logic [SIZE-1:0] out_data;
    logic [AW-1:0]   ram_waddr, ram_raddr;
    logic [SIZE-1:0] ram_wdata, ram_rdata;
    logic            ram_wen, overflow;
    logic [1:0]      lines_held;

    line_buffer_ctrl #(.SIZE(SIZE), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .overflow(overflow), .lines_held(lines_held)
    );

    always #5 clk = ~clk;

    // Simple dual-port RAM with registered read
    logic [SIZE-1:0] mem [2*LW];
    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    logic [SIZE:0] exp_q [$];
    int  m_wcnt = 0;
    bit  m_bank = 0;
    bit  rand_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    // Monitor: pops the scoreboard on each output handshake, checks stall stability
    logic          prev_stall = 1'b0;
    logic [SIZE:0] prev_word;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("stall_valid", {31'b0, out_valid}, 32'd1);
                chk("stall_word", {7'b0, out_last, out_data}, {7'b0, prev_word});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out actual=%0h required=none", {out_last, out_data});
                end else begin
                    logic [SIZE:0] e;
                    e = exp_q.pop_front();
                    chk("out_word", {7'b0, out_last, out_data}, {7'b0, e});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Random backpressure, active only while rand_en is set
    always @(posedge clk) begin
        if (rand_en) begin
            #1;
            out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after the beat is taken
    task automatic send_px(input logic [SIZE-1:0] d, input bit last);
        bit ok = 0;
        bit e_last, e_ovf;
        logic [AW-1:0] e_addr;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            chk("in_ready_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
        end
        e_last = last || (m_wcnt == LW - 1);
        e_ovf  = (m_wcnt == LW - 1) && !last;
        e_addr = AW'(m_bank * LW + m_wcnt);
        chk("ram_wen", {31'b0, ram_wen}, 32'd1);
        chk("ram_waddr", {28'b0, ram_waddr}, {28'b0, e_addr});
        chk("overflow", {31'b0, overflow}, {31'b0, e_ovf});
        exp_q.push_back({e_last, d});
        if (e_last) begin
            m_wcnt = 0;
            m_bank = ~m_bank;
        end else begin
            m_wcnt++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        chk(nm, exp_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int lw, len;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_lines_held", {30'b0, lines_held}, 32'd0);
        chk("rst_ram_wen", {31'b0, ram_wen}, 32'd0);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single 5-pixel line, first output two cycles after the closing write
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_px(24'h111100 + 24'(i), i == 4);
        lw = cyc;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("t1_latency", cyc - lw, 32'd2);
        drain("t1_drain");

        // 2: two lines fill both banks under backpressure, third waits
        out_ready = 1'b0;
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < 4; i++) send_px(24'h220000 + 24'(l * 16 + i), i == 3);
        @(negedge clk);
        chk("t2_lines_held", {30'b0, lines_held}, 32'd2);
        chk("t2_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_px(24'h220020 + 24'(i), i == 3);
        drain("t2_drain");

        // 3: 10 pixels without in_last, truncated at 8
        for (int i = 0; i < 10; i++) send_px(24'h330000 + 24'(i), i == 9);
        drain("t3_drain");

        // 4: random backpressure over random-length lines
        rand_en = 1;
        for (int l = 0; l < 20; l++) begin
            len = $urandom_range(1, LW);
            for (int i = 0; i < len; i++) send_px(24'($urandom), i == len - 1);
        end
        rand_en = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain("t4_drain");

        // 5: reset in the middle of draining
        out_ready = 1'b0;
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < 4; i++) send_px(24'h550000 + 24'(l * 16 + i), i == 3);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t5_out_valid", {31'b0, out_valid}, 32'd0);
        chk("t5_out_last", {31'b0, out_last}, 32'd0);
        chk("t5_out_data", {8'b0, out_data}, 32'd0);
        chk("t5_lines_held", {30'b0, lines_held}, 32'd0);
        chk("t5_ram_wen", {31'b0, ram_wen}, 32'd0);
        chk("t5_overflow", {31'b0, overflow}, 32'd0);
        exp_q.delete();
        m_wcnt = 0;
        m_bank = 0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_in_ready", {31'b0, in_ready}, 32'd1);
        chk("t5_lines_held_rel", {30'b0, lines_held}, 32'd0);
        repeat (10) @(posedge clk);
        #1;

        // 6: back-to-back single-pixel lines alternate banks
        for (int i = 0; i < 6; i++) send_px(24'h660000 + 24'(i), 1'b1);
        drain("t6_drain");

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
